// File: rtl/memory_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memory_bus_arbiter_pkg                                          |
// | Purpose  : Shared MemoryBus types for the arbiter and its clients: packet |
// |            kinds, bus IDs, the BusPacket struct, the arbiter state type   |
// |            and the client-index to BusID mapping.                         |
// | Ports    : none (package)                                                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package memory_bus_arbiter_pkg;

  typedef logic [31:0] memory_address_t;
  typedef logic [31:0] bus_packet_payload_t;

  // Encoding 2'd3 is unused; the arbiter treats it as malformed.
  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_packet_kind;

  // One ID per possible client slot (up to 8 requesters).
  typedef enum logic [2:0] {
    BUSID_0 = 3'd0,
    BUSID_1 = 3'd1,
    BUSID_2 = 3'd2,
    BUSID_3 = 3'd3,
    BUSID_4 = 3'd4,
    BUSID_5 = 3'd5,
    BUSID_6 = 3'd6,
    BUSID_7 = 3'd7
  } BusID;

  typedef struct packed {
    bus_packet_kind      kind;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2,
    ARB_DELIVER   = 2'd3
  } arb_state_t;

  function automatic BusID client_to_busid(input logic [2:0] idx);
    return BusID'(idx);
  endfunction

endpackage : memory_bus_arbiter_pkg
`default_nettype wire

// File: rtl/memory_bus_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational round-robin pick. Returns the first set request  |
// |            bit found searching upward from ptr_i with wrap-around. The    |
// |            pointer register itself lives in the parent.                   |
// | Ports    : req_i       - request vector                                   |
// |            ptr_i       - highest-priority index this cycle (< NUM_CLIENTS)|
// |            grant_o     - one-hot grant                                    |
// |            grant_idx_o - binary index of the grant                        |
// |            any_grant_o - at least one request present                     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   any_grant_o
);

  // One extra bit so ptr + offset can exceed NUM_CLIENTS before wrapping.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = {1'b0, ptr_i} + SW'(i);
      if (cand >= SW'(NUM_CLIENTS)) begin
        cand = cand - SW'(NUM_CLIENTS);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                        = 1'b1;
        grant_idx_o                  = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
    any_grant_o = found;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memory_bus_arbiter                                              |
// | Purpose  : Shares one MemoryBus request/response channel between         |
// |            NUM_CLIENTS requesters with round-robin arbitration and a      |
// |            single outstanding transaction. Read responses are routed      |
// |            back to the issuing client; a watchdog flags lost responses.   |
// | Ports    : clk, reset           - clock, synchronous active-high reset    |
// |            cli_req_*            - client request channel (per client)     |
// |            cli_resp_*           - client response channel (shared packet) |
// |            mem_req_*            - request channel toward memory           |
// |            mem_resp_*           - response channel from memory            |
// |            timeout_err          - sticky: read response never arrived     |
// |            protocol_err         - sticky: unexpected/malformed traffic    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] cli_req_valid,
  input  BusPacket [NUM_CLIENTS-1:0] cli_req_pkt,
  output logic [NUM_CLIENTS-1:0] cli_req_ready,
  output logic [NUM_CLIENTS-1:0] cli_resp_valid,
  output BusPacket               cli_resp_pkt,
  input  logic [NUM_CLIENTS-1:0] cli_resp_ready,
  output logic                   mem_req_valid,
  output BusPacket               mem_req_pkt,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  BusPacket               mem_resp_pkt,
  output logic                   mem_resp_ready,
  output logic                   timeout_err,
  output logic                   protocol_err
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int PW    = IDX_W + 1;

  arb_state_t       state_q,        state_d;
  logic [IDX_W-1:0] rr_ptr_q,       rr_ptr_d;
  logic [IDX_W-1:0] gidx_q,         gidx_d;
  BusPacket         req_pkt_q,      req_pkt_d;
  BusPacket         resp_pkt_q,     resp_pkt_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic             timeout_err_q,  timeout_err_d;
  logic             protocol_err_q, protocol_err_d;

  logic [NUM_CLIENTS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_grant;
  logic [PW-1:0]          ptr_inc;
  logic                   issue_ok;
  logic                   resp_match;
  logic                   timeout_hit;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req_i       (cli_req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign ptr_inc    = {1'b0, grant_idx} + PW'(1);
  assign issue_ok   = (req_pkt_q.kind == bus_read_data) ||
                      (req_pkt_q.kind == bus_write_data);
  // Only a read response carrying the outstanding requester's ID is accepted.
  assign resp_match = mem_resp_valid &&
                      (mem_resp_pkt.kind == bus_read_response) &&
                      (mem_resp_pkt.source == req_pkt_q.source);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign mem_req_pkt  = req_pkt_q;
  assign cli_resp_pkt = resp_pkt_q;
  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gidx_d         = gidx_q;
    req_pkt_d      = req_pkt_q;
    resp_pkt_d     = resp_pkt_q;
    cnt_d          = cnt_q;
    timeout_err_d  = timeout_err_q;
    protocol_err_d = protocol_err_q;
    cli_req_ready  = '0;
    cli_resp_valid = '0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Nothing is outstanding, so any response here is stray.
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          protocol_err_d = 1'b1;
        end
        if (any_grant) begin
          cli_req_ready    = grant;
          gidx_d           = grant_idx;
          req_pkt_d        = cli_req_pkt[grant_idx];
          req_pkt_d.source = client_to_busid(3'(grant_idx));
          rr_ptr_d         = (ptr_inc == PW'(NUM_CLIENTS)) ? '0 : ptr_inc[IDX_W-1:0];
          state_d          = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        if (issue_ok) begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            if (req_pkt_q.kind == bus_read_data) begin
              cnt_d   = '0;
              state_d = ARB_WAIT_RESP;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end else begin
          // Malformed request kind: discarded without reaching memory.
          protocol_err_d = 1'b1;
          state_d        = ARB_IDLE;
        end
      end

      ARB_WAIT_RESP: begin
        mem_resp_ready = 1'b1;
        if (resp_match) begin
          // A valid response on the last watchdog cycle still wins.
          resp_pkt_d = mem_resp_pkt;
          state_d    = ARB_DELIVER;
        end else begin
          if (mem_resp_valid) begin
            protocol_err_d = 1'b1;
          end
          if (timeout_hit) begin
            timeout_err_d = 1'b1;
            state_d       = ARB_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ARB_DELIVER: begin
        cli_resp_valid[gidx_q] = 1'b1;
        if (cli_resp_ready[gidx_q]) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Keep every combinational output quiet while reset is held.
    if (reset) begin
      cli_req_ready  = '0;
      cli_resp_valid = '0;
      mem_req_valid  = 1'b0;
      mem_resp_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= '0;
      gidx_q         <= '0;
      req_pkt_q      <= '0;
      resp_pkt_q     <= '0;
      cnt_q          <= '0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gidx_q         <= gidx_d;
      req_pkt_q      <= req_pkt_d;
      resp_pkt_q     <= resp_pkt_d;
      cnt_q          <= cnt_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule : memory_bus_arbiter
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_memory_bus_arbiter                                           |
// | Purpose  : Self-checking bench for memory_bus_arbiter (4 clients,         |
// |            8-cycle watchdog). Directed scenarios plus a randomized run    |
// |            against a round-robin/transaction reference model.             |
// | Ports    : none                                                           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_memory_bus_arbiter;
  import memory_bus_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     cli_req_valid;
  BusPacket [3:0] cli_req_pkt;
  logic [3:0]     cli_req_ready;
  logic [3:0]     cli_resp_valid;
  BusPacket       cli_resp_pkt;
  logic [3:0]     cli_resp_ready;
  logic           mem_req_valid;
  BusPacket       mem_req_pkt;
  logic           mem_req_ready;
  logic           mem_resp_valid;
  BusPacket       mem_resp_pkt;
  logic           mem_resp_ready;
  logic           timeout_err;
  logic           protocol_err;

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;

  memory_bus_arbiter #(
    .NUM_CLIENTS    (4),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cli_req_valid  (cli_req_valid),
    .cli_req_pkt    (cli_req_pkt),
    .cli_req_ready  (cli_req_ready),
    .cli_resp_valid (cli_resp_valid),
    .cli_resp_pkt   (cli_resp_pkt),
    .cli_resp_ready (cli_resp_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_pkt    (mem_req_pkt),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_pkt   (mem_resp_pkt),
    .mem_resp_ready (mem_resp_ready),
    .timeout_err    (timeout_err),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic BusPacket mk(input bus_packet_kind k, input BusID s,
                                  input logic [31:0] a, input logic [31:0] p);
    BusPacket x;
    x.kind = k; x.source = s; x.address = a; x.payload = p;
    return x;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cli_req_valid  = '0;
    cli_resp_ready = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_pkt   = '0;
    for (int i = 0; i < 4; i++) cli_req_pkt[i] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    nxt(); nxt(); #1;
    vectors++; if ({cli_req_ready, cli_resp_valid, cli_resp_pkt, mem_req_valid, mem_req_pkt, mem_resp_ready, timeout_err, protocol_err} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got req_rdy=%b resp_v=%b mreq_v=%b mresp_rdy=%b terr=%b perr=%b, expected all 0", cli_req_ready, cli_resp_valid, mem_req_valid, mem_resp_ready, timeout_err, protocol_err); end
    reset = 1'b0;
    nxt(); #1;
    vectors++; if ({mem_resp_ready, mem_req_valid, cli_req_ready} !== {1'b1, 1'b0, 4'b0}) begin
      miscompares++; $display("FAIL reset_idle: got mresp_rdy=%b mreq_v=%b req_rdy=%b, expected 1 0 0000", mem_resp_ready, mem_req_valid, cli_req_ready); end
  endtask

  task automatic test_single_read();
    BusPacket exp;
    do_reset();
    cli_req_pkt[2] = mk(bus_read_data, BUSID_0, 32'h100, 32'h0);
    exp = mk(bus_read_data, BUSID_2, 32'h100, 32'h0);
    cli_req_valid = 4'b0100; #1;
    vectors++; if (cli_req_ready !== 4'b0100) begin miscompares++; $display("FAIL rd_req_ready: got %b expected 0100", cli_req_ready); end
    nxt(); cli_req_valid = '0; mem_req_ready = 1'b1; #1;
    vectors++; if ({mem_req_valid, mem_req_pkt} !== {1'b1, exp}) begin miscompares++; $display("FAIL rd_mem_req: got v=%b pkt=%h expected v=1 pkt=%h", mem_req_valid, mem_req_pkt, exp); end
    nxt(); mem_req_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      vectors++; if ({cli_resp_valid, mem_resp_ready} !== {4'b0, 1'b1}) begin miscompares++; $display("FAIL rd_wait: got resp_v=%b mresp_rdy=%b expected 0000 1", cli_resp_valid, mem_resp_ready); end
      nxt();
    end
    mem_resp_pkt = mk(bus_read_response, BUSID_2, 32'h100, 32'hDEADBEEF);
    mem_resp_valid = 1'b1;
    nxt(); mem_resp_valid = 1'b0; #1;
    vectors++; if ({cli_resp_valid, cli_resp_pkt.payload} !== {4'b0100, 32'hDEADBEEF}) begin miscompares++; $display("FAIL rd_deliver: got v=%b payload=%h expected 0100 deadbeef", cli_resp_valid, cli_resp_pkt.payload); end
    nxt(); cli_resp_ready = 4'b1011; #1;
    vectors++; if (cli_resp_valid !== 4'b0100) begin miscompares++; $display("FAIL rd_hold: got %b expected 0100", cli_resp_valid); end
    nxt(); cli_resp_ready = 4'b0100; #1;
    nxt(); cli_resp_ready = '0; #1;
    vectors++; if (cli_resp_valid !== 4'b0000) begin miscompares++; $display("FAIL rd_done: got %b expected 0000", cli_resp_valid); end
  endtask

  task automatic test_rr_writes();
    logic [3:0] seen [10];
    logic [3:0] exp;
    logic       resp_seen;
    do_reset();
    for (int i = 0; i < 4; i++) cli_req_pkt[i] = mk(bus_write_data, BUSID_0, 32'h2000 + 32'(i * 4), 32'(i));
    cli_req_valid = 4'hF; mem_req_ready = 1'b1; resp_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      seen[c] = cli_req_ready;
      if (cli_resp_valid !== 4'b0) resp_seen = 1'b1;
      nxt();
    end
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      exp = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0;
      vectors++; if (seen[c] !== exp) begin miscompares++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, seen[c], exp); end
    end
    vectors++; if (resp_seen !== 1'b0) begin miscompares++; $display("FAIL rr_no_resp: got %b expected 0", resp_seen); end
  endtask

  task automatic test_backpressure();
    BusPacket exp;
    int       hs;
    logic     repulse;
    do_reset();
    cli_req_pkt[1] = mk(bus_write_data, BUSID_3, 32'h3000, 32'hCAFE0001);
    cli_req_pkt[3] = mk(bus_write_data, BUSID_0, 32'h3300, 32'h0);
    exp = mk(bus_write_data, BUSID_1, 32'h3000, 32'hCAFE0001);
    cli_req_valid = 4'b0010; #1;
    vectors++; if (cli_req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: got %b expected 0010", cli_req_ready); end
    nxt(); cli_req_valid = 4'b1000; hs = 0; repulse = 1'b0;
    for (int s = 0; s <= 5; s++) begin
      mem_req_ready = (s == 5); #1;
      vectors++; if ({mem_req_valid, mem_req_pkt} !== {1'b1, exp}) begin miscompares++; $display("FAIL bp_hold cycle %0d: got v=%b pkt=%h expected v=1 pkt=%h", s, mem_req_valid, mem_req_pkt, exp); end
      if (cli_req_ready !== 4'b0) repulse = 1'b1;
      if (mem_req_valid && mem_req_ready) hs++;
      nxt();
    end
    mem_req_ready = 1'b0; #1;
    vectors++; if (hs !== 1) begin miscompares++; $display("FAIL bp_handshakes: got %0d expected 1", hs); end
    vectors++; if (repulse !== 1'b0) begin miscompares++; $display("FAIL bp_repulse: got %b expected 0", repulse); end
    vectors++; if (cli_req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_next_grant: got %b expected 1000", cli_req_ready); end
  endtask

  task automatic test_timeout();
    do_reset();
    cli_req_pkt[1] = mk(bus_read_data, BUSID_1, 32'h4000, 32'h0);
    cli_req_valid = 4'b0010; #1;
    vectors++; if (cli_req_ready !== 4'b0010) begin miscompares++; $display("FAIL to_grant: got %b expected 0010", cli_req_ready); end
    nxt(); cli_req_valid = '0; mem_req_ready = 1'b1;
    nxt(); mem_req_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_early wait cycle %0d: got %b expected 0", c, timeout_err); end
      nxt();
    end
    #1;
    vectors++; if ({timeout_err, cli_resp_valid} !== {1'b1, 4'b0}) begin miscompares++; $display("FAIL to_flag: got terr=%b resp_v=%b expected 1 0000", timeout_err, cli_resp_valid); end
    cli_req_pkt[0] = mk(bus_write_data, BUSID_0, 32'h4100, 32'h0);
    cli_req_valid = 4'b0001;
    mem_resp_pkt = mk(bus_read_response, BUSID_1, 32'h4000, 32'h1234);
    mem_resp_valid = 1'b1; #1;
    vectors++; if ({cli_req_ready, protocol_err} !== {4'b0001, 1'b0}) begin miscompares++; $display("FAIL to_idle: got req_rdy=%b perr=%b expected 0001 0", cli_req_ready, protocol_err); end
    nxt(); clear_inputs(); #1;
    vectors++; if ({protocol_err, timeout_err, cli_resp_valid} !== {1'b1, 1'b1, 4'b0}) begin miscompares++; $display("FAIL to_late_resp: got perr=%b terr=%b resp_v=%b expected 1 1 0000", protocol_err, timeout_err, cli_resp_valid); end
  endtask

  task automatic test_wrong_resp();
    do_reset();
    cli_req_pkt[0] = mk(bus_read_data, BUSID_5, 32'h5000, 32'h0);
    cli_req_valid = 4'b0001;
    nxt(); cli_req_valid = '0; mem_req_ready = 1'b1;
    nxt(); mem_req_ready = 1'b0;
    mem_resp_pkt = mk(bus_read_response, BUSID_3, 32'h5000, 32'hBAD0BAD0);
    mem_resp_valid = 1'b1; #1;
    vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL wr_pre: got %b expected 0", protocol_err); end
    nxt(); mem_resp_valid = 1'b0; #1;
    vectors++; if ({protocol_err, cli_resp_valid} !== {1'b1, 4'b0}) begin miscompares++; $display("FAIL wr_drop: got perr=%b resp_v=%b expected 1 0000", protocol_err, cli_resp_valid); end
    nxt();
    mem_resp_pkt = mk(bus_read_response, BUSID_0, 32'h5000, 32'h600D600D);
    mem_resp_valid = 1'b1;
    nxt(); mem_resp_valid = 1'b0; #1;
    vectors++; if ({cli_resp_valid, cli_resp_pkt.payload} !== {4'b0001, 32'h600D600D}) begin miscompares++; $display("FAIL wr_deliver: got v=%b payload=%h expected 0001 600d600d", cli_resp_valid, cli_resp_pkt.payload); end
  endtask

  task automatic test_reset_deliver();
    do_reset();
    cli_req_pkt[0] = mk(bus_read_data, BUSID_0, 32'h40, 32'h0);
    cli_req_pkt[3] = mk(bus_write_data, BUSID_3, 32'h44, 32'h0);
    cli_req_valid = 4'b0001;
    nxt(); cli_req_valid = '0; mem_req_ready = 1'b1;
    nxt(); mem_req_ready = 1'b0;
    mem_resp_pkt = mk(bus_read_response, BUSID_0, 32'h40, 32'h77);
    mem_resp_valid = 1'b1;
    nxt(); mem_resp_valid = 1'b0; #1;
    vectors++; if (cli_resp_valid !== 4'b0001) begin miscompares++; $display("FAIL rd_pre_reset: got %b expected 0001", cli_resp_valid); end
    reset = 1'b1;
    nxt(); #1;
    vectors++; if ({cli_req_ready, cli_resp_valid, cli_resp_pkt, mem_req_valid, mem_req_pkt, mem_resp_ready, timeout_err, protocol_err} !== '0) begin
      miscompares++; $display("FAIL rst_deliver_outputs: got resp_v=%b pkt=%h mreq_v=%b mresp_rdy=%b, expected all 0", cli_resp_valid, cli_resp_pkt, mem_req_valid, mem_resp_ready); end
    reset = 1'b0;
    cli_req_valid = 4'b1001; #1;
    vectors++; if (cli_req_ready !== 4'b0001) begin miscompares++; $display("FAIL rst_ptr_grant: got %b expected 0001", cli_req_ready); end
    clear_inputs();
  endtask

  task automatic test_bad_kind();
    do_reset();
    cli_req_pkt[2] = mk(bus_read_response, BUSID_2, 32'h6000, 32'h0);
    cli_req_valid = 4'b0100;
    nxt(); cli_req_valid = '0; mem_req_ready = 1'b1; #1;
    vectors++; if ({mem_req_valid, protocol_err} !== 2'b00) begin miscompares++; $display("FAIL bk_not_sent: got mreq_v=%b perr=%b expected 0 0", mem_req_valid, protocol_err); end
    nxt(); mem_req_ready = 1'b0; #1;
    vectors++; if ({protocol_err, mem_resp_ready, mem_req_valid} !== 3'b110) begin miscompares++; $display("FAIL bk_err_idle: got perr=%b mresp_rdy=%b mreq_v=%b expected 1 1 0", protocol_err, mem_resp_ready, mem_req_valid); end
  endtask

  // Reference model: grant = first requester at or after model_ptr (mod 4);
  // every granted packet is forwarded with its source replaced by the grant
  // index; reads return exactly the payload memory supplied.
  task automatic test_random();
    logic [3:0] held, newreq, req, exp_rdy;
    BusPacket   exp, rsp;
    int         g, stall, d, r;
    do_reset();
    model_ptr = 0; held = '0;
    for (int t = 0; t < 60; t++) begin
      newreq = 4'($urandom_range(0, 15));
      req = held | newreq;
      if (req == 4'b0) req = 4'(1 << $urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        if (req[c] && !held[c])
          cli_req_pkt[c] = mk(($urandom_range(0, 1) == 1) ? bus_read_data : bus_write_data,
                              BusID'(3'($urandom_range(0, 7))), $urandom, $urandom);
      end
      cli_req_valid = req; #1;
      g = -1;
      for (int k = 0; k < 4; k++) if (g < 0 && req[(model_ptr + k) % 4]) g = (model_ptr + k) % 4;
      exp_rdy = 4'(1 << g);
      vectors++; if (cli_req_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_grant txn %0d: got %b expected %b (req %b)", t, cli_req_ready, exp_rdy, req); end
      exp = cli_req_pkt[g];
      exp.source = BusID'(3'(g));
      model_ptr = (g + 1) % 4;
      held = req & ~exp_rdy;
      nxt(); cli_req_valid = held;
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        mem_req_ready = (s == stall); #1;
        vectors++; if ({mem_req_valid, mem_req_pkt, cli_req_ready} !== {1'b1, exp, 4'b0}) begin miscompares++; $display("FAIL rnd_issue txn %0d: got v=%b pkt=%h rdy=%b expected v=1 pkt=%h rdy=0000", t, mem_req_valid, mem_req_pkt, cli_req_ready, exp); end
        nxt();
      end
      mem_req_ready = 1'b0;
      if (exp.kind == bus_read_data) begin
        d = $urandom_range(0, 7);
        for (int w = 0; w < d; w++) begin
          #1;
          vectors++; if ({cli_resp_valid, cli_req_ready, timeout_err} !== 9'b0) begin miscompares++; $display("FAIL rnd_wait txn %0d: got resp_v=%b rdy=%b terr=%b expected all 0", t, cli_resp_valid, cli_req_ready, timeout_err); end
          nxt();
        end
        rsp = mk(bus_read_response, BusID'(3'(g)), exp.address, $urandom);
        mem_resp_pkt = rsp; mem_resp_valid = 1'b1;
        nxt(); mem_resp_valid = 1'b0;
        r = $urandom_range(0, 2);
        for (int w = 0; w <= r; w++) begin
          cli_resp_ready = (4'($urandom_range(0, 15)) & ~exp_rdy) | ((w == r) ? exp_rdy : 4'b0); #1;
          vectors++; if ({cli_resp_valid, cli_resp_pkt, cli_req_ready} !== {exp_rdy, rsp, 4'b0}) begin miscompares++; $display("FAIL rnd_deliver txn %0d: got v=%b pkt=%h expected v=%b pkt=%h", t, cli_resp_valid, cli_resp_pkt, exp_rdy, rsp); end
          nxt();
        end
        cli_resp_ready = '0;
      end
    end
    cli_req_valid = '0; #1;
    vectors++; if ({timeout_err, protocol_err} !== 2'b00) begin miscompares++; $display("FAIL rnd_errors: got terr=%b perr=%b expected 0 0", timeout_err, protocol_err); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_writes();
    test_backpressure();
    test_timeout();
    test_wrong_resp();
    test_reset_deliver();
    test_bad_kind();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_memory_bus_arbiter
`default_nettype wire
